// File: rtl/pcle_pkg.sv
// Shared types and constants for the pcle loadable counter scheduler.
// PCLE_SATURATE_EN (in the users of this package) selects saturate-and-halt on wrap.
package pcle_pkg;

    localparam int CNT_W_DEF = 6;
    localparam int ST_W_DEF  = CNT_W_DEF + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_HALT  = 2'd3
    } pcle_state_e;

endpackage

// File: rtl/pcle_rr_arb2.sv
// Two-requester round-robin arbiter with global enable and per-requester mask.
// Requester 0 is load, requester 1 is count; reset favours requester 0.
module pcle_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    input  logic [1:0] i_mask,
    output logic [1:0] o_gnt
);

    logic       r_last;
    logic [1:0] w_req;

    // Grant selection: a lone requester wins, a conflict goes to the non-last winner.
    always_comb begin
        w_req = i_req & ~i_mask & {2{i_en}};
        o_gnt = 2'b00;
        case (w_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    // Last-winner pointer, moved only on granted cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end else begin
            r_last <= r_last;
        end
    end

endmodule

// File: rtl/pcle_cnt_sched.sv
// pcle counter scheduler: arbitrates load vs. count and owns the {s, r, count} state.
// Define PCLE_SATURATE_EN to saturate at all-ones and halt instead of wrapping.
module pcle_cnt_sched
    import pcle_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_pad,
    input  logic             rst_n_pad,
    input  logic             en_pad,
    input  logic             ld_req_pad,
    input  logic [CNT_W+1:0] ld_data_pad,
    output logic             ld_gnt_pad,
    input  logic             cnt_req_pad,
    output logic             cnt_gnt_pad,
    output logic [CNT_W+1:0] q_pad,
    output logic             tc_pad,
    output logic             halt_pad
);

    pcle_state_e      r_state;
    logic [CNT_W+1:0] r_q;
    logic             r_tc;
    logic [1:0]       w_gnt;
    logic [1:0]       w_mask;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_full;
    logic [CNT_W+1:0] w_inc;
    logic             w_wrap;

    pcle_rr_arb2 u_arb (
        .clk    (clk_pad),
        .rst_n  (rst_n_pad),
        .i_en   (en_pad),
        .i_req  ({cnt_req_pad, ld_req_pad}),
        .i_mask (w_mask),
        .o_gnt  (w_gnt)
    );

    assign ld_gnt_pad  = w_gnt[0];
    assign cnt_gnt_pad = w_gnt[1];
    assign q_pad       = r_q;
    assign tc_pad      = r_tc;

    // Increment: count wraps, r toggles on full count, s toggles on full count and r.
    always_comb begin
        w_cnt      = r_q[CNT_W-1:0];
        w_cnt_full = &w_cnt;
        w_wrap     = &r_q;
        w_inc      = {r_q[CNT_W+1] ^ (w_cnt_full & r_q[CNT_W]),
                      r_q[CNT_W] ^ w_cnt_full,
                      w_cnt + CNT_W'(1)};
    end

`ifdef PCLE_SATURATE_EN
    logic r_halt;

    assign halt_pad = r_halt;
    assign w_mask   = {(r_state == ST_HALT), 1'b0};

    // State update with saturate-and-halt on a wrapping increment.
    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) begin
            r_q     <= '0;
            r_tc    <= 1'b0;
            r_halt  <= 1'b0;
            r_state <= ST_IDLE;
        end else if (ld_gnt_pad) begin
            r_q     <= ld_data_pad;
            r_tc    <= 1'b0;
            r_halt  <= 1'b0;
            r_state <= ST_LOAD;
        end else if (cnt_gnt_pad) begin
            r_tc <= w_wrap;
            if (w_wrap) begin
                r_q     <= '1;
                r_halt  <= 1'b1;
                r_state <= ST_HALT;
            end else begin
                r_q     <= w_inc;
                r_halt  <= 1'b0;
                r_state <= ST_COUNT;
            end
        end else begin
            r_q     <= r_q;
            r_tc    <= 1'b0;
            r_halt  <= r_halt;
            r_state <= (r_state == ST_HALT) ? ST_HALT : ST_IDLE;
        end
    end
`else
    assign halt_pad = 1'b0;
    assign w_mask   = 2'b00;

    // State update with free-running wrap; HALT is unreachable in this build.
    always_ff @(posedge clk_pad or negedge rst_n_pad) begin
        if (!rst_n_pad) begin
            r_q     <= '0;
            r_tc    <= 1'b0;
            r_state <= ST_IDLE;
        end else if (ld_gnt_pad) begin
            r_q     <= ld_data_pad;
            r_tc    <= 1'b0;
            r_state <= ST_LOAD;
        end else if (cnt_gnt_pad) begin
            r_q     <= w_inc;
            r_tc    <= w_wrap;
            r_state <= ST_COUNT;
        end else begin
            r_q     <= r_q;
            r_tc    <= 1'b0;
            r_state <= (r_state == ST_HALT) ? ST_HALT : ST_IDLE;
        end
    end
`endif

endmodule

// File: tb/tb_pcle_cnt_sched.sv
// Directed scoreboard bench for pcle_cnt_sched; expected {halt, tc, q} queued at drive time.
module tb_pcle_cnt_sched;

    logic       clk_pad;
    logic       rst_n_pad;
    logic       en_pad;
    logic       ld_req_pad;
    logic [7:0] ld_data_pad;
    logic       ld_gnt_pad;
    logic       cnt_req_pad;
    logic       cnt_gnt_pad;
    logic [7:0] q_pad;
    logic       tc_pad;
    logic       halt_pad;

    typedef struct packed {
        logic       halt;
        logic       tc;
        logic [7:0] q;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    pcle_cnt_sched dut (
        .clk_pad     (clk_pad),
        .rst_n_pad   (rst_n_pad),
        .en_pad      (en_pad),
        .ld_req_pad  (ld_req_pad),
        .ld_data_pad (ld_data_pad),
        .ld_gnt_pad  (ld_gnt_pad),
        .cnt_req_pad (cnt_req_pad),
        .cnt_gnt_pad (cnt_gnt_pad),
        .q_pad       (q_pad),
        .tc_pad      (tc_pad),
        .halt_pad    (halt_pad)
    );

    initial clk_pad = 1'b0;
    always #5 clk_pad = ~clk_pad;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // One clock step: drive at negedge, check grants, check registered result after posedge.
    task automatic step(input string tag, input logic ld, input logic [7:0] data,
                        input logic cnt, input logic en,
                        input logic eg_ld, input logic eg_cnt,
                        input logic [7:0] eq, input logic etc, input logic ehalt);
        exp_t e;
        ld_req_pad  = ld;
        ld_data_pad = data;
        cnt_req_pad = cnt;
        en_pad      = en;
        sb_q.push_back('{halt: ehalt, tc: etc, q: eq});
        #1;
        chk({tag, "_ld_gnt"},  {7'd0, ld_gnt_pad},  {7'd0, eg_ld});
        chk({tag, "_cnt_gnt"}, {7'd0, cnt_gnt_pad}, {7'd0, eg_cnt});
        @(posedge clk_pad);
        #1;
        e = sb_q.pop_front();
        chk({tag, "_q"},    q_pad,               e.q);
        chk({tag, "_tc"},   {7'd0, tc_pad},      {7'd0, e.tc});
        chk({tag, "_halt"}, {7'd0, halt_pad},    {7'd0, e.halt});
        @(negedge clk_pad);
    endtask

    initial begin
        rst_n_pad   = 1'b0;
        en_pad      = 1'b0;
        ld_req_pad  = 1'b0;
        ld_data_pad = 8'h00;
        cnt_req_pad = 1'b0;
        #3;
        chk("rst_q",    q_pad,            8'h00);
        chk("rst_tc",   {7'd0, tc_pad},   8'h00);
        chk("rst_halt", {7'd0, halt_pad}, 8'h00);
        @(negedge clk_pad);
        rst_n_pad = 1'b1;

        // Ten plain increments from reset.
        for (int i = 1; i <= 10; i++)
            step("cnt10", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);

        // Load 0x3F then one count: r toggles.
        step("ld3f",  1'b1, 8'h3F, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3F, 1'b0, 1'b0);
        step("inc3f", 1'b0, 8'h3F, 1'b1, 1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 1'b0);

        // Load all-ones then one count: wrap (or saturate and halt).
        step("ldff",  1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
`ifdef PCLE_SATURATE_EN
        step("wrap",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        step("halt",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
`else
        step("wrap",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        step("tc1cy", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`endif

        // Both requests held: load wins first, then grants alternate.
        step("rr0", 1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        step("rr1", 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
        step("rr2", 1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        step("rr3", 1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);

        // Counting with an enable gap of three cycles.
        step("run0", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
        step("run1", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h13, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("en_lo", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h13, 1'b0, 1'b0);
        step("resume", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 1'b0, 1'b0);

        // Run up to 0x24, then load 0x25 so load becomes the last winner.
        for (int i = 8'h15; i <= 8'h24; i++)
            step("run", 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
        step("ld25", 1'b1, 8'h25, 1'b0, 1'b1, 1'b1, 1'b0, 8'h25, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle, checked before any clock edge.
        cnt_req_pad = 1'b1;
        ld_req_pad  = 1'b0;
        #2;
        rst_n_pad = 1'b0;
        #1;
        chk("arst_q",  q_pad,          8'h00);
        chk("arst_tc", {7'd0, tc_pad}, 8'h00);
        @(negedge clk_pad);
        rst_n_pad = 1'b1;

        // Pointer back at load priority: load wins this conflict.
        step("post_rst", 1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        step("post_rr",  1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pcle_cnt_sched.md
# pcle_cnt_sched

Sequential scheduler that owns the pcle loadable counter state and shares its single update path between a load requester and a count requester. Each cycle it arbitrates between the two requesters, applies exactly one operation (load, increment or hold) and flags the terminal count. It sits between the host-side control ports and the pcle counter next-state datapath, and holds the state register that datapath reads and writes.

## Interface
- CNT_W, 6: width of the low count field; total state width is CNT_W+2 (count, r bit, s bit).
- clk_pad  in  1  clock; all state updates on the rising edge.
- rst_n_pad  in  1  reset, asynchronous, active-low.
- en_pad  in  1  global enable; when low, no grants are issued and the state holds.
- ld_req_pad  in  1  load request; held high until granted.
- ld_data_pad  in  CNT_W+2  load value {s, r, count}; must be stable while ld_req_pad is high.
- ld_gnt_pad  out  1  load grant; combinational; the load completes on the edge where it is high.
- cnt_req_pad  in  1  count request; level; each granted cycle performs one increment.
- cnt_gnt_pad  out  1  count grant; combinational.
- q_pad  out  CNT_W+2  registered state {s, r, count}.
- tc_pad  out  1  registered terminal-count pulse.
- halt_pad  out  1  high while in HALT (only with PCLE_SATURATE_EN).

## Operation
- FSM states: IDLE, LOAD, COUNT, HALT. The state reflects the operation applied on the most recent edge. HALT exists only with the macro.
- Grants are issued only when en_pad=1. At most one grant is high in any cycle.
- Single requester: that requester is granted.
- Both requesting: round-robin on a 1-bit last-winner pointer. After reset the pointer favours load, so load wins the first conflict.
- The pointer updates only on granted cycles.
- Load: q ← ld_data_pad; FSM → LOAD. A load clears HALT.
- Increment:
  - count ← count+1, mod 2^CNT_W.
  - r toggles when count is all ones.
  - s toggles when count and r are both all ones.
  - The whole state therefore behaves as a (CNT_W+2)-bit binary counter.
  - FSM → COUNT.
- Terminal count: an increment with q all ones sets tc_pad=1 for exactly one cycle.
- No grant: q holds; FSM → IDLE, except that HALT persists.
- Simultaneous load and wrap: the arbiter picks one, so they cannot collide. tc_pad is asserted only on a granted wrapping increment.

## Timing
- Reset values: q_pad=0, tc_pad=0, halt_pad=0, FSM=IDLE, pointer=load-priority.
- Grants are derived combinationally from the requests, en_pad, the pointer and the FSM state. There are no combinational paths from ld_data_pad to any output.
- q_pad shows the result of an operation 1 cycle after its grant.
- tc_pad is high in the same cycle q_pad first shows the wrapped value.
- A requester drops its request the cycle after its grant, or keeps it high to request again. A request held continuously while the other requester is idle is granted every cycle.
- en_pad low mid-stream: the state freezes and the pointer is retained; operation resumes on the next enabled cycle.
- Reset asserted mid-operation: all registers return to their reset values immediately (asynchronous). Any grant in flight is discarded. Requests are re-arbitrated after the release edge.

## Configuration
- PCLE_SATURATE_EN undefined: the counter wraps all-ones → 0, tc_pad pulses, counting continues; halt_pad is tied 0.
- PCLE_SATURATE_EN defined, on a wrapping increment:
  - q is forced to all ones and tc_pad pulses.
  - FSM → HALT, halt_pad=1.
  - cnt_gnt_pad stays 0 while halted.
  - Only a granted load leaves HALT, and it wins regardless of the pointer.

## Structure
- Shared package pcle_pkg holds:
  - the FSM state enum typedef (IDLE, LOAD, COUNT, HALT);
  - the CNT_W default as a localparam;
  - the state-width helper constant CNT_W+2.
- One sub-module, pcle_rr_arb2: a 2-requester round-robin arbiter with enable and a per-requester mask input; the mask is used for HALT masking of count.
- Increment/toggle logic stays inline in pcle_cnt_sched.

## Test plan
- Reset then 10 cycles of cnt_req_pad=1, en_pad=1 → q_pad=0x0A, tc_pad never high.
- ld_req_pad=1 with ld_data_pad=0x3F, then one count → q_pad=0x40 (r toggles), tc_pad=0.
- Load 0xFF, then one count:
  - without the macro → q_pad=0x00, tc_pad=1 for one cycle;
  - with the macro → q_pad=0xFF, halt_pad=1, cnt_gnt_pad=0 thereafter.
- Both requests held high for 4 cycles with ld_data_pad=0x10, starting from q=0:
  - grants alternate load, count, load, count;
  - q_pad sequence 0x10, 0x11, 0x10, 0x11.
- Count running, en_pad=0 for 3 cycles → q_pad constant, no grants; counting resumes on re-enable.
- rst_n_pad pulsed low mid-count at q=0x25 → q_pad=0 asynchronously; the next conflict is won by load.
